// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/write-back sequencer owning the PC, instruction register and retire count.
// Optional feature: define INSTR_SEQUENCER_SINGLE_STEP_EN to add the `step` input (one-instruction start).
module instr_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter logic [31:0] HALT_INSN     = 32'h0010_0073,
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
    input  logic        step,
`endif
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    output logic [31:0] pc_value,
    output logic [31:0] instr,
    output logic        decode_valid,
    output logic        reg_write_enable,
    output logic        busy,
    output logic        halted,
    output logic        fetch_error,
    output logic [31:0] retired_count
);

    localparam int unsigned WAIT_W = (FETCH_TIMEOUT > 0) ? $clog2(FETCH_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(FETCH_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        WRITE,
        HALT
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        instr_q, instr_d;
    logic [31:0]        retired_q, retired_d;
    logic               fetch_error_q, fetch_error_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
    logic               step_mode_q, step_mode_d;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        retired_d     = retired_q;
        fetch_error_d = fetch_error_q;
        wait_d        = wait_q;
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
        step_mode_d   = step_mode_q;
`endif
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                    wait_d  = '0;
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
                    step_mode_d = 1'b0;
                end else if (step) begin
                    state_d     = FETCH;
                    wait_d      = '0;
                    step_mode_d = 1'b1;
`endif
                end
            end
            FETCH: begin
                // Ready takes priority over a timeout landing on the same cycle.
                if (mem_ready) begin
                    instr_d = mem_rdata;
                    state_d = DECODE;
                end else if (FETCH_TIMEOUT != 0) begin
                    if (wait_q == WAIT_MAX) begin
                        fetch_error_d = 1'b1;
                        state_d       = HALT;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end
            DECODE: begin
                state_d = (instr_q == HALT_INSN) ? HALT : WRITE;
            end
            WRITE: begin
                pc_d      = pc_q + 32'd4;
                retired_d = retired_q + 32'd1;
                wait_d    = '0;
                state_d   = run ? FETCH : IDLE;
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
                if (step_mode_q) begin
                    state_d = IDLE;
                end
`endif
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= {RESET_PC[31:2], 2'b00};
            instr_q       <= '0;
            retired_q     <= '0;
            fetch_error_q <= 1'b0;
            wait_q        <= '0;
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
            step_mode_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            retired_q     <= retired_d;
            fetch_error_q <= fetch_error_d;
            wait_q        <= wait_d;
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
            step_mode_q   <= step_mode_d;
`endif
        end
    end

    assign mem_req          = (state_q == FETCH);
    assign decode_valid     = (state_q == DECODE);
    assign reg_write_enable = (state_q == WRITE);
    assign halted           = (state_q == HALT);
    assign busy             = (state_q != IDLE) && (state_q != HALT);
    assign mem_addr         = pc_q[31:2];
    assign pc_value         = pc_q;
    assign instr            = instr_q;
    assign fetch_error      = fetch_error_q;
    assign retired_count    = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: random programs/wait states vs a per-instruction reference model.
module tb_instr_sequencer;

    localparam logic [31:0] HALT_W = 32'h0010_0073;
    localparam int unsigned T_MAIN = 3;

    typedef struct {
        bit          is_halt;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] ret;
        bit          err;
    } exp_t;

    logic        clk;
    int unsigned cyc = 0;
    int unsigned n_tests = 0;
    int unsigned n_fail = 0;

    // main instance (short timeout)
    logic        reset_n, run, mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_req, decode_valid, reg_write_enable, busy, halted, fetch_error;
    logic [29:0] mem_addr;
    logic [31:0] pc_value, instr, retired_count;
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
    logic        step;
    logic        step_w;
`endif

    // wrap instance (PC starts at top of address space)
    logic        reset_n_w, run_w, mem_ready_w;
    logic [31:0] mem_rdata_w;
    logic        mem_req_w, decode_valid_w, reg_write_enable_w, busy_w, halted_w, fetch_error_w;
    logic [29:0] mem_addr_w;
    logic [31:0] pc_value_w, instr_w, retired_count_w;

    instr_sequencer #(.FETCH_TIMEOUT(T_MAIN)) dut (
        .clk(clk), .reset_n(reset_n), .run(run),
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
        .step(step),
`endif
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_addr(mem_addr),
        .pc_value(pc_value), .instr(instr), .decode_valid(decode_valid),
        .reg_write_enable(reg_write_enable), .busy(busy), .halted(halted),
        .fetch_error(fetch_error), .retired_count(retired_count)
    );

    instr_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset_n(reset_n_w), .run(run_w),
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
        .step(step_w),
`endif
        .mem_ready(mem_ready_w), .mem_rdata(mem_rdata_w), .mem_req(mem_req_w), .mem_addr(mem_addr_w),
        .pc_value(pc_value_w), .instr(instr_w), .decode_valid(decode_valid_w),
        .reg_write_enable(reg_write_enable_w), .busy(busy_w), .halted(halted_w),
        .fetch_error(fetch_error_w), .retired_count(retired_count_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [16];
    exp_t        exp_q[$];
    int unsigned delay_q[$];
    int unsigned write_cycles[$];

    // reference model state
    logic [31:0] m_pc, m_ret;
    bit          m_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = 32'h0;
        m_ret  = 32'h0;
        m_done = 1'b0;
    endtask

    // one fetch attempt with d wait cycles before ready
    task automatic model_insn(input int unsigned d);
        exp_t e;
        if (m_done) return;
        delay_q.push_back(d);
        e.pc    = m_pc;
        e.ret   = m_ret;
        e.instr = mem[m_pc[5:2]];
        e.err   = 1'b0;
        if (d > T_MAIN) begin
            e.is_halt = 1'b1;
            e.err     = 1'b1;
            m_done    = 1'b1;
        end else if (mem[m_pc[5:2]] == HALT_W) begin
            e.is_halt = 1'b1;
            m_done    = 1'b1;
        end else begin
            e.is_halt = 1'b0;
            m_pc  = m_pc + 32'd4;
            m_ret = m_ret + 32'd1;
        end
        exp_q.push_back(e);
    endtask

    task automatic gen_prog(input int halt_at);
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom();
            if (mem[i] == HALT_W) mem[i] = 32'h0000_0013;
        end
        if (halt_at >= 0) mem[halt_at] = HALT_W;
    endtask

    // memory responder: ready after the scheduled number of wait cycles
    int unsigned rcnt = 0;
    int unsigned rdly = 0;
    always @(negedge clk) begin
        if (mem_req) begin
            if (rcnt == 0) rdly = (delay_q.size() != 0) ? delay_q.pop_front() : 0;
            mem_ready = (rcnt == rdly);
            mem_rdata = mem_ready ? mem[mem_addr[3:0]] : $urandom();
            rcnt++;
        end else begin
            rcnt      = 0;
            mem_ready = 1'($urandom_range(1, 0));
            mem_rdata = $urandom();
        end
    end

    task automatic sb_check(input bit is_halt);
        exp_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got %s event pc=%h, expected no event", is_halt ? "halt" : "write", pc_value);
            return;
        end
        e = exp_q.pop_front();
        if (e.is_halt != is_halt || pc_value !== e.pc || retired_count !== e.ret ||
            fetch_error !== e.err || (!is_halt && instr !== e.instr)) begin
            n_fail++;
            $display("FAIL sb_%s: got pc=%h instr=%h ret=%h err=%b, expected %s pc=%h instr=%h ret=%h err=%b",
                     is_halt ? "halt" : "write", pc_value, instr, retired_count, fetch_error,
                     e.is_halt ? "halt" : "write", e.pc, e.instr, e.ret, e.err);
        end
    endtask

    // monitor
    bit          halted_prev = 1'b0;
    int unsigned flen = 0;
    int unsigned last_flen = 0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (reg_write_enable) begin
                write_cycles.push_back(cyc);
                sb_check(1'b0);
            end
            if (halted && !halted_prev) sb_check(1'b1);
            if (mem_req) flen++;
            else if (flen != 0) begin
                last_flen = flen;
                flen      = 0;
            end
        end else begin
            flen = 0;
        end
        halted_prev = halted;
    end

    task automatic reset_main();
        reset_n = 1'b0;
        run     = 1'b0;
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
        step    = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        delay_q.delete();
        write_cycles.delete();
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic wait_halt(input int unsigned budget, input string name);
        int unsigned k = 0;
        while (!halted && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_halt"}, {31'b0, halted}, 32'd1);
        repeat (2) @(negedge clk);
        chk({name, "_sb_drained"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned k;
        int unsigned fc;
        logic [31:0] w;
        reset_n     = 1'b0;
        run         = 1'b0;
        reset_n_w   = 1'b0;
        run_w       = 1'b0;
        mem_ready_w = 1'b0;
        mem_rdata_w = '0;
        mem_ready   = 1'b0;
        mem_rdata   = '0;
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
        step   = 1'b0;
        step_w = 1'b0;
`endif
        gen_prog(-1);

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_pc", pc_value, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_retired", retired_count, 32'h0);
        chk("rst_strobes", {27'b0, mem_req, decode_valid, reg_write_enable, busy, halted}, 32'h0);
        chk("rst_err", {31'b0, fetch_error}, 32'h0);

        // three instructions then halt, zero-wait memory
        reset_main();
        gen_prog(3);
        while (!m_done) model_insn(0);
        run = 1'b1;
        wait_halt(100, "basic");
        chk("basic_writes", write_cycles.size(), 32'd3);
        if (write_cycles.size() >= 3) begin
            chk("basic_gap1", write_cycles[1] - write_cycles[0], 32'd3);
            chk("basic_gap2", write_cycles[2] - write_cycles[1], 32'd3);
        end
        for (int i = 0; i < 6; i++) begin
            run = 1'($urandom_range(1, 0));
            @(negedge clk);
        end
        chk("halt_terminal", {30'b0, halted, busy}, 32'h2);
        chk("halt_retired", retired_count, 32'd3);

        // fetch timeout on the second instruction
        reset_main();
        gen_prog(8);
        model_insn(1);
        model_insn(9);
        run = 1'b1;
        wait_halt(100, "timeout");
        chk("timeout_fetch_cycles", last_flen, T_MAIN + 1);

        // random programs and wait states
        for (int it = 0; it < 8; it++) begin
            reset_main();
            gen_prog(int'($urandom_range(14, 2)));
            while (!m_done)
                model_insn(($urandom_range(7, 0) == 0) ? $urandom_range(6, 4) : $urandom_range(3, 0));
            run = 1'b1;
            wait_halt(400, "random");
        end

        // run drops during DECODE of the second instruction
        reset_main();
        gen_prog(5);
        while (!m_done) model_insn($urandom_range(2, 0));
        run = 1'b1;
        k = 0;
        while (!(decode_valid && retired_count == 32'd1) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("drop_reached_decode", {31'b0, decode_valid}, 32'd1);
        run = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < 20);
        chk("drop_idle", {30'b0, busy, halted}, 32'h0);
        chk("drop_pc", pc_value, 32'h8);
        chk("drop_retired", retired_count, 32'd2);
        chk("drop_writes", write_cycles.size(), 32'd2);
        run = 1'b1;
        @(negedge clk);
        chk("resume_fetch", {1'b0, mem_req, mem_addr}, {2'b01, 30'd2});
        wait_halt(200, "resume");

`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
        // single-step with run low
        reset_main();
        gen_prog(1);
        model_insn(0);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (8) @(negedge clk);
        chk("step_writes", write_cycles.size(), 32'd1);
        chk("step_idle", {30'b0, busy, halted}, 32'h0);
        chk("step_retired", retired_count, 32'd1);
        chk("step_pc", pc_value, 32'h4);
        chk("step_sb_drained", exp_q.size(), 32'd0);
`endif

        // wrap instance: 4 wait cycles, PC wrap, async reset mid-FETCH
        w = $urandom();
        if (w == HALT_W) w = 32'h0000_0013;
        @(negedge clk);
        reset_n_w = 1'b1;
        run_w     = 1'b1;
        @(negedge clk);
        chk("w_first_fetch", {1'b0, mem_req_w, mem_addr_w}, {2'b01, 30'h3FFF_FFFF});
        fc = cyc;
        repeat (4) @(negedge clk);
        chk("w_still_fetch", {31'b0, mem_req_w}, 32'd1);
        mem_ready_w = 1'b1;
        mem_rdata_w = w;
        @(negedge clk);
        mem_ready_w = 1'b0;
        mem_rdata_w = $urandom();
        run_w       = 1'b0;
        chk("w_decode_instr", instr_w, w);
        chk("w_decode_valid", {31'b0, decode_valid_w}, 32'd1);
        @(negedge clk);
        chk("w_write", {31'b0, reg_write_enable_w}, 32'd1);
        chk("w_latency", cyc - fc + 1, 32'd7);
        chk("w_pc_before", pc_value_w, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("w_pc_wrap", pc_value_w, 32'h0);
        chk("w_addr_wrap", {2'b0, mem_addr_w}, 32'h0);
        chk("w_retired", retired_count_w, 32'd1);
        chk("w_no_err", {30'b0, fetch_error_w, busy_w}, 32'h0);
        run_w = 1'b1;
        @(negedge clk);
        chk("w_fetch2", {31'b0, mem_req_w}, 32'd1);
        #2 reset_n_w = 1'b0;
        #1;
        chk("w_rst_req", {28'b0, mem_req_w, decode_valid_w, reg_write_enable_w, busy_w}, 32'h0);
        chk("w_rst_pc", pc_value_w, 32'hFFFF_FFFC);
        chk("w_rst_retired", retired_count_w, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle control FSM for the single-issue core. It sequences the program counter, instruction memory, decoder and register file through fetch, decode and write-back phases, replacing the free-running PC/always-write arrangement. It owns the PC and instruction register, issues a request/ready handshake to instruction memory, gates the register-file write enable and halts on a designated halt instruction or a fetch timeout.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value after reset; must be word aligned.
- `HALT_INSN`, 32'h0010_0073, instruction word that stops the sequencer.
- `FETCH_TIMEOUT`, 15, maximum wait cycles in FETCH before error; 0 disables the timeout.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  reset; asynchronous assert, active-low.
- `run`  in  1  level; permits starting or continuing instruction execution.
- `mem_ready`  in  1  instruction memory has valid `mem_rdata` for the current request.
- `mem_rdata`  in  32  fetched instruction word.
- `mem_req`  out  1  fetch request; high in FETCH only.
- `mem_addr`  out  30  word address, equal to `pc_value[31:2]`.
- `pc_value`  out  32  current PC.
- `instr`  out  32  instruction register, feeding the decoder.
- `decode_valid`  out  1  `instr` holds a fresh word; high in DECODE only.
- `reg_write_enable`  out  1  register-file write strobe; high in WRITE only.
- `busy`  out  1  high in any state except IDLE and HALT.
- `halted`  out  1  high in HALT.
- `fetch_error`  out  1  sticky; set when a fetch timeout occurs.
- `retired_count`  out  32  number of instructions that reached WRITE.

## Operation
- States: IDLE, FETCH, DECODE, WRITE, HALT.
- IDLE: if `run` = 1, go to FETCH; otherwise stay.
- FETCH:
  - `mem_req` = 1.
  - If `mem_ready` = 1, latch `instr` <= `mem_rdata` and go to DECODE.
  - Otherwise increment the wait counter.
  - If `FETCH_TIMEOUT` != 0 and the counter reaches `FETCH_TIMEOUT` with `mem_ready` still 0, set `fetch_error` and go to HALT.
  - The wait counter clears on entry to FETCH.
- DECODE:
  - `decode_valid` = 1.
  - If `instr` == `HALT_INSN`, go to HALT. The PC and `retired_count` are unchanged, and there is no register write.
  - Otherwise go to WRITE.
- WRITE:
  - `reg_write_enable` = 1.
  - `pc_value` <= `pc_value` + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - `retired_count` += 1, wraps at 2^32.
  - Next state is FETCH if `run` = 1, else IDLE.
- HALT: terminal; exits only by reset. `run` and `mem_ready` are ignored.
- `mem_ready` is ignored outside FETCH.
- Deasserting `run` mid-instruction does not abort it; the instruction completes WRITE, then the FSM goes to IDLE.
- Reset values: state IDLE, `pc_value` = `RESET_PC`, `instr` = 0, `retired_count` = 0, `fetch_error` = 0, wait counter = 0, and all strobes (`mem_req`, `decode_valid`, `reg_write_enable`, `busy`, `halted`) = 0.

## Timing
- All outputs are registered state or decodes of the state register only; there are no combinational paths from inputs to outputs.
- Zero-wait memory: FETCH, DECODE and WRITE each take 1 cycle, so an instruction takes 3 cycles.
  - With `run` held high, throughput is 1 instruction per 3 cycles.
  - `reg_write_enable` pulses every 3rd cycle.
- Each cycle of `mem_ready` = 0 in FETCH adds one cycle of latency.
- The timeout fires on the edge where the counter would pass `FETCH_TIMEOUT`, i.e. after `FETCH_TIMEOUT` + 1 FETCH cycles without ready. If `mem_ready` arrives on that same cycle, ready wins.
- `pc_value` changes on the edge that leaves WRITE. `mem_addr` for the next fetch is therefore valid in the first FETCH cycle.
- Asynchronous reset mid-operation:
  - Strobes drop immediately and state returns to IDLE with no register write.
  - After deassertion, the first FETCH occurs no earlier than the second rising edge.

## Configuration
- `INSTR_SEQUENCER_SINGLE_STEP_EN` defined:
  - Adds input `step` (1 bit).
  - In IDLE, `step` = 1 with `run` = 0 starts exactly one instruction.
  - After that instruction's WRITE, the FSM returns to IDLE regardless of `run`.
  - `run` = 1 keeps its normal free-run behaviour and has priority over `step`.
- Undefined: no `step` port; behaviour exactly as in Operation.

## Test plan
- Reset release, `run` = 1, `mem_ready` tied 1, memory holds 3 non-halt words then `HALT_INSN` at word 3:
  - `reg_write_enable` pulses 3 times, 3 cycles apart.
  - Ends with `halted` = 1, `pc_value` = 0x0C, `retired_count` = 3.
- Memory wait states: `mem_ready` low for 4 cycles in FETCH.
  - `instr` latches on the ready cycle.
  - Instruction latency is 7 cycles.
  - `fetch_error` stays 0.
- Timeout: `FETCH_TIMEOUT` = 3 and `mem_ready` held 0.
  - After 4 FETCH cycles: `fetch_error` = 1, `halted` = 1, `retired_count` unchanged.
- `run` drops during DECODE of the 2nd instruction:
  - WRITE still pulses.
  - `retired_count` = 2, `pc_value` = 0x08.
  - FSM returns to IDLE with `busy` = 0; reasserting `run` resumes fetching at word 2.
- Wrap: `RESET_PC` = 32'hFFFF_FFFC with a non-halt word.
  - After WRITE, `pc_value` = 0 and `mem_addr` = 0.
  - Assert `reset_n` = 0 mid-FETCH: `mem_req` drops immediately and the PC returns to `RESET_PC`.
- With `INSTR_SEQUENCER_SINGLE_STEP_EN` defined, `run` = 0 and a one-cycle `step` pulse:
  - Exactly one `reg_write_enable` pulse, then IDLE.
  - `retired_count` = 1.
